// File: rtl/decode_stage_pipe.sv
// Decode stage: splits a 16-bit instruction, reads operands with write-back bypass,
// builds the immediate and registers everything into a valid/ready decode/execute register.
module decode_stage_pipe #(
  parameter int XLEN     = 16,
  parameter int NREGS    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     ir,
  input  logic [15:0]     pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [3:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      rdout,
  output logic [3:0]      op,
  output logic [15:0]     pcout
);

  // Address is backed by storage and is not the hard-wired zero register.
  function automatic logic addr_ok(input logic [3:0] addr);
    return ({1'b0, addr} < 5'(NREGS)) && !((ZERO_REG != 0) && (addr == 4'd0));
  endfunction

  logic [XLEN-1:0] regs_r [16];
  logic [3:0]      rd_s, rs1_s, rs2_s, opc_s;
  logic            wb_legal_s;
  logic            load_s;
  logic            stall_s;
  logic [XLEN-1:0] rv1_s, rv2_s, imm_s;

  logic            out_valid_r;
  logic [XLEN-1:0] a_r, b_r, imm_r;
  logic [3:0]      rdout_r, op_r, rs1_r, rs2_r;
  logic [15:0]     pcout_r;

  assign rd_s       = ir[15:12];
  assign rs1_s      = ir[11:8];
  assign rs2_s      = ir[7:4];
  assign opc_s      = ir[3:0];
  assign wb_legal_s = wb_en && addr_ok(wb_addr);
  assign in_ready   = !flush && (!out_valid_r || out_ready);
  assign load_s     = in_valid && in_ready;
  assign stall_s    = out_valid_r && !out_ready;

  // Operand read with same-cycle write-back bypass.
  always_comb begin
    rv1_s = '0;
    rv2_s = '0;
    if (!addr_ok(rs1_s)) begin
      rv1_s = '0;
    end else if (wb_legal_s && (wb_addr == rs1_s)) begin
      rv1_s = wb_data;
    end else begin
      rv1_s = regs_r[rs1_s];
    end
    if (!addr_ok(rs2_s)) begin
      rv2_s = '0;
    end else if (wb_legal_s && (wb_addr == rs2_s)) begin
      rv2_s = wb_data;
    end else begin
      rv2_s = regs_r[rs2_s];
    end
  end

  // Immediate generation, format chosen by the upper opcode bits.
  always_comb begin
    imm_s = '0;
    case (opc_s[3:2])
      2'b00:   imm_s = '0;
      2'b01:   imm_s = {{(XLEN-4){ir[7]}}, ir[7:4]};
      2'b10:   imm_s = {{(XLEN-8){ir[11]}}, ir[11:4]};
      2'b11:   imm_s = {{(XLEN-9){ir[11]}}, ir[11:4], 1'b0};
      default: imm_s = '0;
    endcase
  end

  // Architectural register file; entries past NREGS and a zero r0 are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_legal_s) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Decode/execute register: load on accept, refresh held operands on write-back while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      imm_r       <= '0;
      rdout_r     <= 4'd0;
      op_r        <= 4'd0;
      pcout_r     <= 16'd0;
      rs1_r       <= 4'd0;
      rs2_r       <= 4'd0;
    end else begin
      if (flush) begin
        out_valid_r <= 1'b0;
      end else if (load_s) begin
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (load_s) begin
        a_r     <= rv1_s;
        b_r     <= rv2_s;
        imm_r   <= imm_s;
        rdout_r <= rd_s;
        op_r    <= opc_s;
        pcout_r <= pc;
        rs1_r   <= rs1_s;
        rs2_r   <= rs2_s;
      end else if (stall_s && wb_legal_s) begin
        if (wb_addr == rs1_r) begin
          a_r <= wb_data;
        end
        if (wb_addr == rs2_r) begin
          b_r <= wb_data;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign a         = a_r;
  assign b         = b_r;
  assign imm       = imm_r;
  assign rdout     = rdout_r;
  assign op        = op_r;
  assign pcout     = pcout_r;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe with a register-file model and an output scoreboard.
module tb_decode_stage_pipe;

  localparam int XLEN     = 16;
  localparam int NREGS    = 16;
  localparam int ZERO_REG = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     ir;
  logic [15:0]     pc;
  logic            flush;
  logic            wb_en;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a, b, imm;
  logic [3:0]      rdout, op;
  logic [15:0]     pcout;

  decode_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ir(ir), .pc(pc),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .imm(imm),
    .rdout(rdout), .op(op), .pcout(pcout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [3:0]      rd;
    logic [3:0]      op;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic [15:0]     pc;
  } item_t;

  item_t           q[$];
  logic [XLEN-1:0] mregs [16];
  logic            mvalid;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic wb_legal();
    return wb_en && (int'(wb_addr) < NREGS) && !((ZERO_REG != 0) && (wb_addr == 4'd0));
  endfunction

  function automatic logic [XLEN-1:0] mread(input logic [3:0] addr);
    if ((int'(addr) >= NREGS) || ((ZERO_REG != 0) && (addr == 4'd0))) return '0;
    if (wb_legal() && (wb_addr == addr)) return wb_data;
    return mregs[addr];
  endfunction

  function automatic logic [XLEN-1:0] mimm(input logic [15:0] iv);
    logic [XLEN-1:0] r;
    case (iv[3:2])
      2'b01:   r = XLEN'($signed(iv[7:4]));
      2'b10:   r = XLEN'($signed(iv[11:4]));
      2'b11:   r = XLEN'($signed(iv[11:4])) << 1;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    q.delete();
    mvalid = 1'b0;
  endtask

  task automatic tick();
    logic  exp_rdy, accept, popit, nvalid, wl;
    item_t it;
    #1;
    exp_rdy = !flush && (!mvalid || out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    wl     = wb_legal();
    accept = in_valid && exp_rdy;
    it     = '0;
    if (accept) begin
      it.a = mread(ir[11:8]);  it.b = mread(ir[7:4]);  it.imm = mimm(ir);
      it.rd = ir[15:12];       it.op = ir[3:0];        it.rs1 = ir[11:8];
      it.rs2 = ir[7:4];        it.pc = pc;
    end
    popit = mvalid && (flush || out_ready);
    if (mvalid && !out_ready && wl && (q.size() > 0)) begin
      if (q[0].rs1 == wb_addr) q[0].a = wb_data;
      if (q[0].rs2 == wb_addr) q[0].b = wb_data;
    end
    nvalid = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : mvalid;
    @(posedge clk);
    if (popit && (q.size() > 0)) void'(q.pop_front());
    if (accept) q.push_back(it);
    mvalid = nvalid;
    if (wl) mregs[wb_addr] = wb_data;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
    if (mvalid) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        chk("a",     32'(a),     32'(q[0].a));
        chk("b",     32'(b),     32'(q[0].b));
        chk("imm",   32'(imm),   32'(q[0].imm));
        chk("rdout", 32'(rdout), 32'(q[0].rd));
        chk("op",    32'(op),    32'(q[0].op));
        chk("pcout", 32'(pcout), 32'(q[0].pc));
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] irv, input logic [15:0] pcv,
                       input logic ordy, input logic fl, input logic we,
                       input logic [3:0] wa, input logic [XLEN-1:0] wd);
    in_valid = iv; ir = irv; pc = pcv; out_ready = ordy; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_a"},     32'(a),     32'd0);
    chk({tag, "_b"},     32'(b),     32'd0);
    chk({tag, "_imm"},   32'(imm),   32'd0);
    chk({tag, "_rdout"}, 32'(rdout), 32'd0);
    chk({tag, "_op"},    32'(op),    32'd0);
    chk({tag, "_pcout"}, 32'(pcout), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ir = 16'd0; pc = 16'd0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = '0; out_ready = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    #1 chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // write then decode
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3, 16'h1234);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd4, 16'h00FF);
    drive(1'b1, 16'h2341, 16'h0100, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    // bypass and zero register
    drive(1'b1, 16'h1302, 16'h0102, 1'b1, 1'b0, 1'b1, 4'd3, 16'hBEEF);
    drive(1'b1, 16'h1004, 16'h0104, 1'b1, 1'b0, 1'b1, 4'd0, 16'hFFFF);
    drive(1'b1, 16'h1004, 16'h0106, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    // immediate modes
    drive(1'b1, 16'h0F85, 16'h0108, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1'b1, 16'h0F0A, 16'h010A, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1'b1, 16'h07FF, 16'h010C, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);

    // stall with operand refresh; write to held rd leaves rdout alone
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3, 16'h1234);
    drive(1'b1, 16'h2341, 16'h0200, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1'b1, 16'h5671, 16'h0202, 1'b0, 1'b0, 1'b1, 4'd4, 16'hAAAA);
    drive(1'b1, 16'h5671, 16'h0202, 1'b0, 1'b0, 1'b1, 4'd3, 16'h5555);
    drive(1'b1, 16'h5671, 16'h0202, 1'b0, 1'b0, 1'b1, 4'd2, 16'h7777);
    drive(1'b1, 16'h5671, 16'h0202, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);

    // flush over a held instruction, then normal accept
    drive(1'b1, 16'h3450, 16'h0300, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1'b1, 16'h89AB, 16'h0302, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000);
    drive(1'b1, 16'h89AB, 16'h0302, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);

    // asynchronous reset while stalled
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd5, 16'h5A5A);
    drive(1'b1, 16'h0500, 16'h0400, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    chk("in_ready_in_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1'b1, 16'h0500, 16'h0402, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    chk("r5_after_reset", 32'(a), 32'd0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
